// File: rtl/text_banner.sv
// Pixel-text overlay: N_CHARS writable glyph slots rendered from a built-in 5x7 font,
// scaled by GLYPH_SCALE, with static, blink and right-to-left scroll modes.
module text_banner #(
    parameter int N_CHARS      = 8,
    parameter int GLYPH_SCALE  = 4,
    parameter int CHAR_PITCH   = 24,
    parameter int BLINK_FRAMES = 30,
    parameter int SCROLL_STEP  = 2,
    parameter int SCREEN_W     = 640,
    localparam int AW = (N_CHARS > 1) ? $clog2(N_CHARS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [9:0]    origin_x,
    input  logic [9:0]    origin_y,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [5:0]    wr_code,
    output logic          display,
    output logic          wrap_pulse
);
    localparam int SPAN    = N_CHARS * CHAR_PITCH;
    localparam int TEXT_H  = 7 * GLYPH_SCALE;
    localparam int OFF_LIM = SCREEN_W + SPAN;
    localparam int OFF_W   = $clog2(OFF_LIM + SCROLL_STEP + 1);
    localparam int CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic signed [11:0] SPAN_S     = 12'(SPAN);
    localparam logic signed [11:0] TEXT_H_S   = 12'(TEXT_H);
    localparam logic signed [11:0] SCREEN_W_S = 12'(SCREEN_W);

    // Row 0 occupies bits [34:30]; within a row the MSB is the leftmost column.
    function automatic logic [34:0] glyph(input logic [5:0] code);
        logic [34:0] g;
        case (code)
            6'd1:  g = 35'b01110_10001_10001_11111_10001_10001_10001;
            6'd2:  g = 35'b11110_10001_10001_11110_10001_10001_11110;
            6'd3:  g = 35'b01110_10001_10000_10000_10000_10001_01110;
            6'd4:  g = 35'b11110_10001_10001_10001_10001_10001_11110;
            6'd5:  g = 35'b11111_10000_10000_11110_10000_10000_11111;
            6'd6:  g = 35'b11111_10000_10000_11110_10000_10000_10000;
            6'd7:  g = 35'b01110_10001_10000_10111_10001_10001_01111;
            6'd8:  g = 35'b10001_10001_10001_11111_10001_10001_10001;
            6'd9:  g = 35'b01110_00100_00100_00100_00100_00100_01110;
            6'd10: g = 35'b00111_00010_00010_00010_00010_10010_01100;
            6'd11: g = 35'b10001_10010_10100_11000_10100_10010_10001;
            6'd12: g = 35'b10000_10000_10000_10000_10000_10000_11111;
            6'd13: g = 35'b10001_11011_10101_10101_10001_10001_10001;
            6'd14: g = 35'b10001_10001_11001_10101_10011_10001_10001;
            6'd15: g = 35'b01110_10001_10001_10001_10001_10001_01110;
            6'd16: g = 35'b11110_10001_10001_11110_10000_10000_10000;
            6'd17: g = 35'b01110_10001_10001_10001_10101_10010_01101;
            6'd18: g = 35'b11110_10001_10001_11110_10100_10010_10001;
            6'd19: g = 35'b01111_10000_10000_01110_00001_00001_11110;
            6'd20: g = 35'b11111_00100_00100_00100_00100_00100_00100;
            6'd21: g = 35'b10001_10001_10001_10001_10001_10001_01110;
            6'd22: g = 35'b10001_10001_10001_10001_10001_01010_00100;
            6'd23: g = 35'b10001_10001_10001_10101_10101_10101_01010;
            6'd24: g = 35'b10001_10001_01010_00100_01010_10001_10001;
            6'd25: g = 35'b10001_10001_10001_01010_00100_00100_00100;
            6'd26: g = 35'b11111_00001_00010_00100_01000_10000_11111;
            6'd27: g = 35'b01110_10001_10011_10101_11001_10001_01110;
            6'd28: g = 35'b00100_01100_00100_00100_00100_00100_01110;
            6'd29: g = 35'b01110_10001_00001_00010_00100_01000_11111;
            6'd30: g = 35'b11111_00010_00100_00010_00001_10001_01110;
            6'd31: g = 35'b00010_00110_01010_10010_11111_00010_00010;
            6'd32: g = 35'b11111_10000_11110_00001_00001_10001_01110;
            6'd33: g = 35'b00110_01000_10000_11110_10001_10001_01110;
            6'd34: g = 35'b11111_00001_00010_00100_01000_01000_01000;
            6'd35: g = 35'b01110_10001_10001_01110_10001_10001_01110;
            6'd36: g = 35'b01110_10001_10001_01111_00001_00010_01100;
            default: g = '0;
        endcase
        return g;
    endfunction

    function automatic logic font_bit(input logic [5:0] code, input logic [2:0] row,
                                      input logic [2:0] col);
        logic [34:0] g;
        logic [5:0]  pos;
        g   = glyph(code);
        pos = 6'(34 - 5 * int'(row) - int'(col));
        return g[pos];
    endfunction

    logic [5:0]       slot_q [N_CHARS];
    logic [5:0]       slot_d [N_CHARS];
    logic [OFF_W-1:0] offset_q, offset_d, off_sum;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             visible_q, visible_d;
    logic             wrap_q, wrap_d;

    logic             hit_p1_q, hit_p1_d;
    logic [2:0]       row_p1_q, row_p1_d;
    logic [2:0]       col_p1_q, col_p1_d;
    logic [5:0]       code_p1_q, code_p1_d;
    logic             display_q, display_d;

    logic signed [11:0] xs, ys, ox_s, oy_s, left_x, dx, dy;
    logic [10:0]        dx_u, dy_u;
    logic               in_box;
    int                 idx_i, col_i, row_i;

    always_comb begin
        slot_d = slot_q;
        if (wr_en && (int'(wr_addr) < N_CHARS)) begin
            slot_d[wr_addr] = wr_code;
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        visible_d   = visible_q;
        offset_d    = offset_q;
        wrap_d      = 1'b0;
        off_sum     = offset_q + OFF_W'(SCROLL_STEP);
        if (enable) begin
            if (!mode[0]) begin
                blink_cnt_d = '0;
                visible_d   = 1'b1;
            end else if (frame_tick) begin
                if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt_d = '0;
                    visible_d   = !visible_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
            if (!mode[1]) begin
                offset_d = '0;
            end else if (frame_tick) begin
                // Wrap once the whole string has left the screen on the left.
                if (off_sum >= OFF_W'(OFF_LIM)) begin
                    offset_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = off_sum;
                end
            end
        end
    end

    // Stage 1: hit test and glyph-cell addressing
    always_comb begin
        xs     = signed'({2'b00, x});
        ys     = signed'({2'b00, y});
        ox_s   = signed'({2'b00, origin_x});
        oy_s   = signed'({2'b00, origin_y});
        left_x = mode[1] ? (ox_s + SCREEN_W_S - signed'(12'(offset_q))) : ox_s;
        dx     = xs - left_x;
        dy     = ys - oy_s;
        dx_u   = dx[10:0];
        dy_u   = dy[10:0];
        idx_i  = int'(dx_u) / CHAR_PITCH;
        col_i  = (int'(dx_u) % CHAR_PITCH) / GLYPH_SCALE;
        row_i  = int'(dy_u) / GLYPH_SCALE;
        in_box = !dx[11] && (dx < SPAN_S) && !dy[11] && (dy < TEXT_H_S);
        hit_p1_d  = in_box && (col_i < 5);
        row_p1_d  = hit_p1_d ? 3'(row_i) : 3'd0;
        col_p1_d  = hit_p1_d ? 3'(col_i) : 3'd0;
        code_p1_d = hit_p1_d ? slot_q[AW'(idx_i)] : 6'd0;
    end

    // Stage 2: font lookup gated by blink visibility and enable
    always_comb begin
        display_d = hit_p1_q && font_bit(code_p1_q, row_p1_q, col_p1_q) && visible_q && enable;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CHARS; i++) begin
                slot_q[i] <= '0;
            end
            offset_q    <= '0;
            blink_cnt_q <= '0;
            visible_q   <= 1'b1;
            wrap_q      <= 1'b0;
            hit_p1_q    <= 1'b0;
            row_p1_q    <= '0;
            col_p1_q    <= '0;
            code_p1_q   <= '0;
            display_q   <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            offset_q    <= offset_d;
            blink_cnt_q <= blink_cnt_d;
            visible_q   <= visible_d;
            wrap_q      <= wrap_d;
            hit_p1_q    <= hit_p1_d;
            row_p1_q    <= row_p1_d;
            col_p1_q    <= col_p1_d;
            code_p1_q   <= code_p1_d;
            display_q   <= display_d;
        end
    end

    assign display    = display_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_text_banner.sv
// Bench for text_banner: pixel-level reference model checked every cycle, plus
// hand-computed pixel, latency, blink, scroll-wrap and reset expectations.
module tb_text_banner;
    logic       clk = 1'b0;
    logic       reset, frame_tick, enable, wr_en;
    logic [1:0] mode;
    logic [9:0] origin_x, origin_y, x, y;
    logic [2:0] wr_addr;
    logic [5:0] wr_code;
    logic       display, wrap_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Reference state: string contents, scroll offset, blink count/visibility.
    int m_str[8];
    int m_off, m_cnt;
    bit m_vis, m_p1, m_disp, m_wrap;

    text_banner dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable), .mode(mode),
        .origin_x(origin_x), .origin_y(origin_y), .x(x), .y(y), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_code(wr_code), .display(display), .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    function automatic string glyph_row(int code, int r);
        string g[7];
        case (code)
            7:  g = '{".###.", "#...#", "#....", "#.###", "#...#", "#...#", ".####"};
            8:  g = '{"#...#", "#...#", "#...#", "#####", "#...#", "#...#", "#...#"};
            14: g = '{"#...#", "#...#", "##..#", "#.#.#", "#..##", "#...#", "#...#"};
            15: g = '{".###.", "#...#", "#...#", "#...#", "#...#", "#...#", ".###."};
            16: g = '{"####.", "#...#", "#...#", "####.", "#....", "#....", "#...."};
            default: g = '{".....", ".....", ".....", ".....", ".....", ".....", "....."};
        endcase
        return g[r];
    endfunction

    function automatic bit model_pixel(int px, int py, int ox, int oy, bit scroll, int off);
        int    l, dx, dy, c;
        string s;
        l  = scroll ? (ox + 640 - off) : ox;
        dx = px - l;
        dy = py - oy;
        if (dx < 0 || dx >= 8 * 24 || dy < 0 || dy >= 28) return 1'b0;
        c = (dx % 24) / 4;
        if (c >= 5) return 1'b0;
        s = glyph_row(m_str[dx / 24], dy / 4);
        return s[c] == "#";
    endfunction

    always @(posedge clk) begin : model
        bit pix;
        if (reset) begin
            foreach (m_str[i]) m_str[i] = 0;
            m_off = 0; m_cnt = 0; m_vis = 1'b1;
            m_p1 = 1'b0; m_disp = 1'b0; m_wrap = 1'b0;
        end else begin
            pix    = model_pixel(int'(x), int'(y), int'(origin_x), int'(origin_y), mode[1], m_off);
            m_disp = m_p1 & m_vis & enable;
            m_p1   = pix;
            m_wrap = 1'b0;
            if (enable) begin
                if (!mode[0]) begin
                    m_cnt = 0; m_vis = 1'b1;
                end else if (frame_tick) begin
                    m_cnt++;
                    if (m_cnt == 30) begin m_cnt = 0; m_vis = !m_vis; end
                end
                if (!mode[1]) m_off = 0;
                else if (frame_tick) begin
                    m_off += 2;
                    if (m_off >= 640 + 192) begin m_off = 0; m_wrap = 1'b1; end
                end
            end
            if (wr_en) m_str[wr_addr] = int'(wr_code);
        end
    end

    task automatic chk(string name, logic got, logic want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (x=%0d y=%0d t=%0t)", name, got, want, x, y, $time);
        end
    endtask

    task automatic chk_int(string name, int got, int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_display", display, m_disp);
            chk("model_wrap", wrap_pulse, m_wrap);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_px(int px, int py);
        x = 10'(px);
        y = 10'(py);
    endtask

    task automatic pix_chk(string name, int px, int py, logic want);
        set_px(px, py);
        cyc(2);
        chk(name, display, want);
    endtask

    task automatic wr(int a, int c);
        wr_en = 1'b1; wr_addr = 3'(a); wr_code = 6'(c);
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic tick_pulse(output logic w);
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        w = wrap_pulse;
        cyc(1);
    endtask

    initial begin
        logic w;
        int   first_wrap, wraps;
        reset = 1'b1; frame_tick = 1'b0; enable = 1'b1; mode = 2'b00;
        origin_x = 10'd100; origin_y = 10'd50; x = '0; y = '0;
        wr_en = 1'b0; wr_addr = '0; wr_code = '0;
        cyc(3);
        reset = 1'b0;
        chk_on = 1'b1;
        chk("rst_display", display, 1'b0);
        chk("rst_wrap", wrap_pulse, 1'b0);

        wr(0, 16); wr(1, 15); wr(2, 14); wr(3, 7);
        for (int yy = 48; yy <= 79; yy++) begin
            for (int xx = 96; xx <= 198; xx++) begin
                set_px(xx, yy);
                cyc(1);
            end
        end

        set_px(99, 50);
        cyc(3);
        set_px(104, 50);
        cyc(1);
        chk("latency_1clk", display, 1'b0);
        cyc(1);
        chk("latency_2clk", display, 1'b1);
        pix_chk("gap_120_50", 120, 50, 1'b0);
        pix_chk("left_99_50", 99, 50, 1'b0);
        pix_chk("below_100_78", 100, 78, 1'b0);
        pix_chk("P_r0c0", 100, 50, 1'b1);
        pix_chk("P_r0c4", 116, 50, 1'b0);
        pix_chk("P_r6c0", 100, 77, 1'b1);
        pix_chk("O_r0c1", 128, 50, 1'b1);
        pix_chk("N_r2c2", 156, 58, 1'b0);
        pix_chk("G_r3c4", 188, 62, 1'b1);

        // Slot 2 holds 'N' (row2 col1 lit); overwrite with 'H' (row2 col1 dark) mid-scan.
        set_px(152, 58);
        cyc(2);
        wr_en = 1'b1; wr_addr = 3'd2; wr_code = 6'd8;
        cyc(1);
        wr_en = 1'b0;
        cyc(1);
        chk("write_old_glyph", display, 1'b1);
        cyc(1);
        chk("write_new_glyph", display, 1'b0);
        wr(2, 14);

        set_px(100, 50);
        mode = 2'b01;
        cyc(2);
        for (int k = 1; k <= 60; k++) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(3);
            chk($sformatf("blink_tick%0d", k), display, ((k / 30) % 2) == 0);
        end
        mode = 2'b00;
        cyc(3);
        chk("blink_cleared", display, 1'b1);

        mode = 2'b10;
        cyc(1);
        tick_pulse(w);
        pix_chk("scroll1_738", 738, 50, 1'b1);
        pix_chk("scroll1_737", 737, 50, 1'b0);
        first_wrap = 0;
        wraps = (w === 1'b1) ? 1 : 0;
        for (int k = 2; k <= 416; k++) begin
            tick_pulse(w);
            if (w === 1'b1) begin
                wraps++;
                if (first_wrap == 0) first_wrap = k;
            end
        end
        chk_int("wrap_tick", first_wrap, 416);
        chk_int("wrap_count", wraps, 1);
        chk("wrap_width", wrap_pulse, 1'b0);
        pix_chk("wrap_740", 740, 50, 1'b1);
        pix_chk("wrap_738", 738, 50, 1'b0);

        repeat (10) tick_pulse(w);
        pix_chk("en_720", 720, 50, 1'b1);
        enable = 1'b0;
        repeat (5) tick_pulse(w);
        pix_chk("en_off", 720, 50, 1'b0);
        enable = 1'b1;
        pix_chk("en_resume_720", 720, 50, 1'b1);
        pix_chk("en_resume_718", 718, 50, 1'b0);

        mode = 2'b11;
        repeat (40) tick_pulse(w);
        pix_chk("pre_reset_hidden", 640, 50, 1'b0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid_reset_display", display, 1'b0);
        pix_chk("mid_reset_blank", 740, 50, 1'b0);
        wr(0, 16);
        pix_chk("mid_reset_off0_vis", 740, 50, 1'b1);

        cyc(2);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
